fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 28 ++
 rtl/fetch_stage_if.sv | 31 +++
 rtl/fetch_stage_ifid_reg.sv | 55 +++++
 rtl/fetch_stage.sv | 116 +++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions for the fetch stage: FSM encoding, NOP word,
// word size, default halt threshold and small arithmetic helpers.
package fetch_stage_pkg;

   // Fetch FSM states, 2-bit encoding.
   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_WORD          = 32'd0;
   localparam logic [31:0] WORD_BYTES        = 32'd4;
   localparam logic [31:0] DEFAULT_HALT_ADDR = 32'd128;
   localparam logic [31:0] DEFAULT_RESET_PC  = 32'd0;
   localparam logic [31:0] COUNT_MAX         = 32'hFFFF_FFFF;

   // Force a byte address onto a word boundary.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

   // Increment that sticks at the all-ones value instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
      return (cnt == COUNT_MAX) ? cnt : cnt + 32'd1;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its environment (hazard unit,
// branch unit, instruction memory and the decode stage).
interface fetch_stage_if;

   logic        stall_i;
   logic        flush_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_data_i;
   logic [31:0] pc_o;
   logic [31:0] ifid_pc4_o;
   logic [31:0] ifid_instr_o;
   logic        ifid_valid_o;
   logic        halt_o;
   logic [31:0] fetch_count_o;

   // The fetch stage itself.
   modport master (
      input  stall_i, flush_i, redirect_pc_i, imem_data_i,
      output imem_addr_o, pc_o, ifid_pc4_o, ifid_instr_o, ifid_valid_o,
             halt_o, fetch_count_o
   );

   // The surrounding pipeline / memory model.
   modport slave (
      output stall_i, flush_i, redirect_pc_i, imem_data_i,
      input  imem_addr_o, pc_o, ifid_pc4_o, ifid_instr_o, ifid_valid_o,
             halt_o, fetch_count_o
   );

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register. Priority: clear (inject NOP) > hold > load.
// With no control asserted the register keeps its contents.
module ifid_reg
   import fetch_stage_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        hold_i,
   input  logic        clear_i,
   input  logic        load_i,
   input  logic [31:0] pc4_i,
   input  logic [31:0] instr_i,
   output logic [31:0] pc4_o,
   output logic [31:0] instr_o,
   output logic        valid_o
);

   logic [31:0] pc4_d,   pc4_q;
   logic [31:0] instr_d, instr_q;
   logic        valid_d, valid_q;

   // Next-value selection for the IF/ID contents.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
      pc4_d   = pc4_q;
      instr_d = instr_q;
      valid_d = valid_q;
      if (clear_i) begin
         instr_d = NOP_WORD;
         valid_d = 1'b0;
      end else if (!hold_i && load_i) begin
         pc4_d   = pc4_i;
         instr_d = instr_i;
         valid_d = 1'b1;
      end
   end

   // IF/ID storage, asynchronously cleared while rst_i is low.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         pc4_q   <= 32'd0;
         instr_q <= NOP_WORD;
         valid_q <= 1'b0;
      end else begin
         pc4_q   <= pc4_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign pc4_o   = pc4_q;
   assign instr_o = instr_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALTED control FSM,
// accepted-instruction counter and the IF/ID pipeline register.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter logic [31:0] HALT_ADDR = DEFAULT_HALT_ADDR
) (
   input  logic          clk_i,
   input  logic          rst_i,
   fetch_stage_if.master bus
);

   fetch_state_e state_d, state_q;
   logic [31:0]  pc_d,    pc_q;
   logic [31:0]  count_d, count_q;
   logic         halt_d,  halt_q;

   logic [31:0]  seq_pc;
   logic [31:0]  redirect_pc;
   logic         ifid_hold;
   logic         ifid_clear;
   logic         ifid_load;

   // PC+4 wraps naturally modulo 2^32; the halt compare sees the wrapped value.
   assign seq_pc      = pc_q + WORD_BYTES;
   assign redirect_pc = align_word(bus.redirect_pc_i);

   // Next-state, next-PC and IF/ID control for the fetch FSM.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      count_d    = count_q;
      halt_d     = halt_q;
      ifid_hold  = 1'b0;
      ifid_clear = 1'b0;
      ifid_load  = 1'b0;

      unique case (state_q)
         ST_BOOT: begin
            // One idle edge after reset release; IF/ID keeps its reset NOP.
            state_d   = ST_RUN;
            ifid_hold = 1'b1;
         end

         ST_RUN: begin
            if (bus.flush_i) begin
               // Taken branch wins over a stall: redirect and squash IF/ID.
               pc_d       = redirect_pc;
               ifid_clear = 1'b1;
               if (redirect_pc > HALT_ADDR) begin
                  state_d = ST_HALTED;
                  halt_d  = 1'b1;
               end
            end else if (bus.stall_i) begin
               ifid_hold = 1'b1;
            end else begin
               // Normal fetch; the word is latched even on the halting edge.
               pc_d      = seq_pc;
               ifid_load = 1'b1;
               count_d   = sat_inc(count_q);
               if (seq_pc > HALT_ADDR) begin
                  state_d = ST_HALTED;
                  halt_d  = 1'b1;
               end
            end
         end

         ST_HALTED: begin
            // Keep feeding NOPs so downstream stages drain; only reset exits.
            ifid_clear = 1'b1;
         end

         default: begin
            // Unreachable encoding: recover through BOOT.
            state_d    = ST_BOOT;
            ifid_clear = 1'b1;
         end
      endcase
   end

   // FSM, PC, counter and halt flag; all discarded at once while rst_i is low.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
         count_q <= 32'd0;
         halt_q  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         pc_q    <= pc_d;
         count_q <= count_d;
         halt_q  <= halt_d;
      end
   end

   ifid_reg u_ifid_reg (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .hold_i  (ifid_hold),
      .clear_i (ifid_clear),
      .load_i  (ifid_load),
      .pc4_i   (seq_pc),
      .instr_i (bus.imem_data_i),
      .pc4_o   (bus.ifid_pc4_o),
      .instr_o (bus.ifid_instr_o),
      .valid_o (bus.ifid_valid_o)
   );

   assign bus.imem_addr_o   = pc_q;
   assign bus.pc_o          = pc_q;
   assign bus.halt_o        = halt_q;
   assign bus.fetch_count_o = count_q;

endmodule
